clint_bus_arbiter: RTL and testbench
====================================

// Module: clint_bus_arbiter
// PURPOSE
//  Round-robin arbiter sharing one timer/interrupt (CLINT) slave port among N_REQ native-bus requesters.
//  Sits between the cores' peripheral buses and the CLINT; one transaction in flight at a time.
//  Captures the winning request, drives the slave until ready, and returns the response to the winner.
//  A watchdog aborts transactions the slave never answers.
// PARAMETERS
//  ADDR_W     32  address width
//  DATA_W     32  data width; wstrb width is DATA_W/8
//  N_REQ      2   number of requesters (>=1); index width IW = max(1,$clog2(N_REQ))
//  TIMEOUT_W  4   watchdog counter width (>=2); limit TMAX = 2**TIMEOUT_W-1 BUSY cycles
// PORTS
//  clk          in   1                 system clock
//  reset        in   1                 synchronous, active-high reset
//  req_valid    in   N_REQ             per-requester request valid
//  req_address  in   N_REQ*ADDR_W      packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata    in   N_REQ*DATA_W      packed write data
//  req_wstrb    in   N_REQ*DATA_W/8    packed byte strobes (all-zero = read)
//  req_rdata    out  DATA_W            response data, shared; valid only with req_ready
//  req_ready    out  N_REQ             one-hot, one-cycle response pulse to the granted requester
//  valid        out  1                 slave request valid
//  address      out  ADDR_W            slave address
//  wdata        out  DATA_W            slave write data
//  wstrb        out  DATA_W/8          slave strobes, passed unmodified
//  rdata        in   DATA_W            slave response data
//  ready        in   1                 slave response ready
//  timeout      out  1                 one-cycle pulse, coincident with req_ready, on watchdog abort
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, cnt=0; valid, address, wdata, wstrb, req_ready, req_rdata, timeout all 0.
//  All outputs registered. FSM states: IDLE, BUSY, RESP.
//  IDLE: if any req_valid: grant g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod N_REQ.
//   Capture req_address/wdata/wstrb of g into output regs; valid<=1; rr_ptr<=(g+1) mod N_REQ; cnt<=0; ->BUSY.
//   No request: remain IDLE, valid=0.
//  BUSY: valid=1; address/wdata/wstrb held stable (captured values; requester changes ignored).
//   ready=1: req_rdata<=rdata, req_ready[g]<=1, valid<=0, ->RESP.
//   else if cnt==TMAX-1: req_rdata<=0, req_ready[g]<=1, timeout<=1, valid<=0, ->RESP (abort).
//   else cnt<=cnt+1.
//   ready wins over timeout in the same cycle (timeout stays 0).
//  RESP: req_ready/timeout high this cycle only, cleared next cycle; no arbitration; ->IDLE.
//   A requester still holding req_valid in RESP is not re-granted for the completed transaction.
//  Latency: req_valid seen in IDLE cycle 0 -> valid at cycle 1; slave ready in cycle k -> req_ready in cycle k+1.
//   Minimum turnaround is 3 cycles (IDLE, BUSY, RESP).
//  Requester dropping req_valid after grant: transaction still completes; req_ready pulse still issued.
//  ready while in IDLE or RESP: ignored.
//  Reset mid-transaction: transaction dropped, no req_ready pulse; all outputs 0 on the next cycle.
//   Arbitration restarts from requester 0.
//  N_REQ==1: rr_ptr is constant 0; same FSM.
// TESTING
//  T1 Read, req 0 to 0xBFF8; slave ready 2 cycles after valid with rdata 0x00001234
//     -> req_ready=2'b01 for exactly one cycle, req_rdata=0x00001234.
//  T2 Both requesters valid continuously from reset, slave ready after 1 cycle
//     -> grants 0,1,0,1,...; never two req_ready bits set at once.
//  T3 Write, req 1 to 0x4000, wdata 0xDEADBEEF, wstrb 4'hF, requester changes address after grant
//     -> slave sees 0x4000 / 0xDEADBEEF / 4'hF stable until ready.
//  T4 Slave never ready, TIMEOUT_W=4 -> valid high exactly 15 cycles, then drops;
//     req_ready pulse with req_rdata=0 and timeout=1.
//  T5 ready arrives in the 15th BUSY cycle -> normal completion with slave rdata; timeout stays 0.
//  T6 reset asserted during BUSY -> next cycle valid=0, req_ready=0;
//     after release, with both requesting, req 0 is granted first.

Source files
------------

// File: rtl/clint_bus_arbiter.sv
// Round-robin arbiter sharing one CLINT slave port among N_REQ native-bus requesters.
// One transaction in flight; a watchdog aborts transactions the slave never answers.
module clint_bus_arbiter #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned N_REQ     = 2,
   parameter int unsigned TIMEOUT_W = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ*ADDR_W-1:0]       req_address,
   input  logic [N_REQ*DATA_W-1:0]       req_wdata,
   input  logic [N_REQ*(DATA_W/8)-1:0]   req_wstrb,
   output logic [DATA_W-1:0]             req_rdata,
   output logic [N_REQ-1:0]              req_ready,
   output logic                          valid,
   output logic [ADDR_W-1:0]             address,
   output logic [DATA_W-1:0]             wdata,
   output logic [DATA_W/8-1:0]           wstrb,
   input  logic [DATA_W-1:0]             rdata,
   input  logic                          ready,
   output logic                          timeout
);

   localparam int unsigned SW   = DATA_W / 8;
   localparam int unsigned IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned TMAX = (2 ** TIMEOUT_W) - 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                state, state_nxt;
   logic [IW-1:0]         rr_ptr, rr_ptr_nxt;
   logic [IW-1:0]         gnt, gnt_nxt;
   logic [TIMEOUT_W-1:0]  cnt, cnt_nxt;
   logic                  valid_nxt, timeout_nxt;
   logic [ADDR_W-1:0]     address_nxt;
   logic [DATA_W-1:0]     wdata_nxt, req_rdata_nxt;
   logic [SW-1:0]         wstrb_nxt;
   logic [N_REQ-1:0]      req_ready_nxt;
   logic                  found;
   logic [IW-1:0]         pick;

   // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         int unsigned idx;
         idx = 32'(rr_ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && req_valid[IW'(idx)]) begin
            found = 1'b1;
            pick  = IW'(idx);
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      rr_ptr_nxt    = rr_ptr;
      gnt_nxt       = gnt;
      cnt_nxt       = cnt;
      valid_nxt     = valid;
      address_nxt   = address;
      wdata_nxt     = wdata;
      wstrb_nxt     = wstrb;
      req_rdata_nxt = req_rdata;
      req_ready_nxt = '0;
      timeout_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               gnt_nxt     = pick;
               address_nxt = req_address[ADDR_W*32'(pick) +: ADDR_W];
               wdata_nxt   = req_wdata[DATA_W*32'(pick) +: DATA_W];
               wstrb_nxt   = req_wstrb[SW*32'(pick) +: SW];
               valid_nxt   = 1'b1;
               rr_ptr_nxt  = (32'(pick) == N_REQ - 1) ? '0 : IW'(pick + IW'(1));
               cnt_nxt     = '0;
               state_nxt   = BUSY;
            end else begin
               valid_nxt = 1'b0;
            end
         end
         BUSY: begin
            // Slave response takes priority over a simultaneous watchdog expiry.
            if (ready) begin
               req_rdata_nxt = rdata;
               req_ready_nxt = N_REQ'(1) << gnt;
               valid_nxt     = 1'b0;
               state_nxt     = RESP;
            end else if (cnt == TIMEOUT_W'(TMAX - 1)) begin
               req_rdata_nxt = '0;
               req_ready_nxt = N_REQ'(1) << gnt;
               timeout_nxt   = 1'b1;
               valid_nxt     = 1'b0;
               state_nxt     = RESP;
            end else begin
               cnt_nxt = cnt + TIMEOUT_W'(1);
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         gnt       <= '0;
         cnt       <= '0;
         valid     <= 1'b0;
         address   <= '0;
         wdata     <= '0;
         wstrb     <= '0;
         req_rdata <= '0;
         req_ready <= '0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_ptr_nxt;
         gnt       <= gnt_nxt;
         cnt       <= cnt_nxt;
         valid     <= valid_nxt;
         address   <= address_nxt;
         wdata     <= wdata_nxt;
         wstrb     <= wstrb_nxt;
         req_rdata <= req_rdata_nxt;
         req_ready <= req_ready_nxt;
         timeout   <= timeout_nxt;
      end
   end

endmodule

// File: tb/tb_clint_bus_arbiter.sv
// Randomized bench for clint_bus_arbiter against a transaction-level reference model.
module tb_clint_bus_arbiter;

   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned N_REQ     = 2;
   localparam int unsigned TIMEOUT_W = 4;
   localparam int unsigned SW        = DATA_W / 8;
   localparam int          TMAX      = (2 ** TIMEOUT_W) - 1;
   localparam int          NCYC      = 4000;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [N_REQ-1:0]         req_valid;
   logic [N_REQ*ADDR_W-1:0]  req_address;
   logic [N_REQ*DATA_W-1:0]  req_wdata;
   logic [N_REQ*SW-1:0]      req_wstrb;
   logic [DATA_W-1:0]        req_rdata;
   logic [N_REQ-1:0]         req_ready;
   logic                     valid;
   logic [ADDR_W-1:0]        address;
   logic [DATA_W-1:0]        wdata;
   logic [SW-1:0]            wstrb;
   logic [DATA_W-1:0]        rdata;
   logic                     ready;
   logic                     timeout;

   clint_bus_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_REQ(N_REQ), .TIMEOUT_W(TIMEOUT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_address(req_address), .req_wdata(req_wdata),
      .req_wstrb(req_wstrb), .req_rdata(req_rdata), .req_ready(req_ready),
      .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
      .rdata(rdata), .ready(ready), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: owner of the in-flight transaction, BUSY cycles spent, response cycle flag.
   int                m_owner = -1;
   int                m_busy  = 0;
   bit                m_resp  = 1'b0;
   int                m_next  = 0;
   logic              exp_valid;
   logic [N_REQ-1:0]  exp_ready;
   logic              exp_to;
   logic [DATA_W-1:0] exp_rdata;
   logic [ADDR_W-1:0] exp_addr;
   logic [DATA_W-1:0] exp_wdata;
   logic [SW-1:0]     exp_wstrb;

   task automatic model_step();
      if (reset) begin
         m_owner = -1; m_busy = 0; m_resp = 1'b0; m_next = 0;
         exp_valid = 1'b0; exp_ready = '0; exp_to = 1'b0; exp_rdata = '0;
         exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
         return;
      end
      exp_ready = '0;
      exp_to    = 1'b0;
      if (m_resp) begin
         m_resp = 1'b0;
      end else if (m_owner >= 0) begin
         m_busy++;
         if (ready || m_busy == TMAX) begin
            exp_rdata          = ready ? rdata : '0;
            exp_to             = !ready;
            exp_ready[m_owner] = 1'b1;
            exp_valid          = 1'b0;
            m_owner            = -1;
            m_resp             = 1'b1;
         end
      end else begin
         for (int k = N_REQ - 1; k >= 0; k--) begin
            int i;
            i = (m_next + k) % N_REQ;
            if (req_valid[i]) m_owner = i;
         end
         if (m_owner >= 0) begin
            exp_addr  = req_address[m_owner*ADDR_W +: ADDR_W];
            exp_wdata = req_wdata[m_owner*DATA_W +: DATA_W];
            exp_wstrb = req_wstrb[m_owner*SW +: SW];
            exp_valid = 1'b1;
            m_next    = (m_owner + 1) % N_REQ;
            m_busy    = 0;
         end
      end
   endtask

   task automatic drive(input int cyc);
      int ready_pct;
      int dens;
      case ((cyc / 250) % 4)
         0: ready_pct = 50;
         1: ready_pct = 7;
         2: ready_pct = 0;
         default: ready_pct = 100;
      endcase
      dens  = ((cyc % 500) < 250) ? 85 : 25;
      reset = (cyc < 3) || ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N_REQ; i++) begin
         req_valid[i]                  = ($urandom_range(0, 99) < dens);
         req_address[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom());
         req_wdata[i*DATA_W +: DATA_W]   = DATA_W'($urandom());
         req_wstrb[i*SW +: SW]           = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom());
      end
      ready = ($urandom_range(0, 99) < ready_pct);
      rdata = DATA_W'($urandom());
   endtask

   initial begin
      reset = 1'b1; req_valid = '0; req_address = '0; req_wdata = '0;
      req_wstrb = '0; rdata = '0; ready = 1'b0;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         drive(cyc);
         @(posedge clk);
         model_step();
         #1;
         check("valid", 64'(valid), 64'(exp_valid));
         check("req_ready", 64'(req_ready), 64'(exp_ready));
         check("timeout", 64'(timeout), 64'(exp_to));
         if (exp_valid) begin
            check("address", 64'(address), 64'(exp_addr));
            check("wdata", 64'(wdata), 64'(exp_wdata));
            check("wstrb", 64'(wstrb), 64'(exp_wstrb));
         end
         if (exp_ready != '0) check("req_rdata", 64'(req_rdata), 64'(exp_rdata));
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
